diff_freq_serial_in: RTL
========================

Name: diff_freq_serial_in

Overview:
- Receive-side counterpart of the dual-frequency serial output block.
- Deserialises a DATA_BIT-wide frame from a single idle-low serial line.
- Each bit period is selected per bit as low speed (10 kHz) or high speed (20 kHz), from a 10 MHz system clock.
- Armed by the same start/stop/mode controls as the transmitter, so one controller drives both ends in lockstep. Used for loopback checking and for links carrying these frames.

Parameters:
- DATA_BIT, 8, frame width in bits.
- TICK_10K_HZ, 1000, clk cycles per low-speed bit.
- TICK_20K_HZ, 500, clk cycles per high-speed bit.

Ports:
- clk  input  1  system clock, 10 MHz.
- rst_n  input  1  reset, asynchronous, active-high.
- i_sel_freq  input  1  bit rate for the next bit: 0 = low (TICK_10K_HZ), 1 = high (TICK_20K_HZ).
- i_start  input  1  one-cycle pulse; arms reception.
- i_stop  input  1  abort / terminate repeat mode.
- i_mode  input  1  0 = one-shot, 1 = repeat; sampled with i_start.
- i_serial  input  1  serial line, idle low, LSB first.
- o_bit_tick  output  1  one-cycle pulse at the end of each bit period.
- o_data  output  DATA_BIT  last complete received frame.
- o_done_tick  output  1  one-cycle pulse when a frame completes.
- o_busy  output  1  high while in RECV.

Behaviour:
- Reset: all outputs 0; state IDLE; shift register, counters and sync flops cleared.
- Input conditioning: i_serial passes through a 2-flop synchroniser; the sampled signal is the synchroniser output.
- States: IDLE, RECV.
- IDLE:
  - On i_start=1 and i_stop=0 → RECV next cycle.
  - Latch i_mode and i_sel_freq; clear tick counter and bit counter to 0.
  - If i_start and i_stop are high in the same cycle, stop wins and the block stays in IDLE.
- RECV bit timing:
  - Tick counter runs 0..P-1, where P = TICK_20K_HZ if the latched sel is 1, else TICK_10K_HZ.
  - At count == P>>1, the synchronised line is sampled into shift register bit [bit_cnt] (LSB first).
  - At count == P-1: o_bit_tick=1 for one cycle, counter→0, bit_cnt increments, i_sel_freq is re-latched for the next bit.
- Per-bit frequency: i_sel_freq is observed only at frame start and at bit boundaries. Changes mid-bit have no effect on the current bit.
- Frame end: the bit_cnt==DATA_BIT-1 boundary also asserts o_done_tick in the same cycle as o_bit_tick, and loads o_data with the shift register including the final sample.
  - One-shot → IDLE.
  - Repeat with i_stop=0 → stay in RECV, bit_cnt=0, new frame begins with no gap.
- i_stop high in RECV: abort immediately → IDLE next cycle. No done tick; o_data keeps its previous value; a partial frame is discarded.
- i_start in RECV: ignored.
- Frame length: sum of the selected bit periods. Done tick arrives that many cycles after the first RECV cycle, minus 1.
- rst_n asserted mid-frame: immediate return to reset values; o_data cleared.

Optional Feature:
- Macro MAJORITY_VOTE_EN.
- Defined: the bit value is the 2-of-3 majority of synchronised samples at counts (P>>1)-1, P>>1 and (P>>1)+1, rejecting single-cycle glitches. The decision is taken at (P>>1)+1.
- Undefined: single sample at P>>1.
- Timing of o_bit_tick, o_done_tick and o_data is identical in both builds.

Test Plan:
- 0x55, i_sel_freq=1, one-shot, driven in lockstep from a transmitter model → o_done_tick about 4000 cycles after start; o_data=0x55; 8 o_bit_ticks spaced 500 cycles; o_busy low afterwards.
- 0xAA, i_sel_freq=0, one-shot → done about 8000 cycles after start; o_data=0xAA; tick spacing 1000.
- 0x55, start high-speed, toggle i_sel_freq after each o_bit_tick → bit spacings 500,1000,500,…; done about 6000 cycles; o_data=0x55.
- Repeat mode, frames 0x3C then 0xC3 at high speed, i_stop mid third frame:
  - Two done ticks 4000 cycles apart; o_data=0x3C then 0xC3.
  - After stop: no third done tick, o_data stays 0xC3, IDLE.
- Abort and reset:
  - i_stop at bit 3 of 0xFF → no done tick, o_data unchanged.
  - i_start+i_stop in the same cycle → remains IDLE.
  - rst_n pulsed mid-frame → o_data=0, IDLE.
- MAJORITY_VOTE_EN, 0x00 high speed, with a 1-cycle high glitch injected at each bit's mid-sample point → o_data=0x00. Same stimulus without the macro → o_data=0xFF.

Source files
------------

// File: rtl/diff_freq_serial_in.sv
`timescale 1ns/1ps
// diff_freq_serial_in
// Receive side of the dual-frequency serial link. Deserialises a DATA_BIT
// frame, LSB first, from an idle-low line. Each bit lasts TICK_20K_HZ or
// TICK_10K_HZ clocks, chosen by i_sel_freq at frame start and at every bit
// boundary. The start/stop/mode controls match the transmitter, so one
// controller can drive both ends in lockstep.
//
// Build option: define MAJORITY_VOTE_EN to decide each bit by a 2-of-3 vote
// over the samples around mid-bit. This rejects single-cycle glitches. Output
// timing is the same with and without the option.
//
// rst_n is asynchronous and active-high; the name is kept as it is used
// elsewhere in the codebase.
module diff_freq_serial_in #(
   parameter int DATA_BIT    = 8,
   parameter int TICK_10K_HZ = 1000,
   parameter int TICK_20K_HZ = 500
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_sel_freq,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_mode,
   input  logic                i_serial,
   output logic                o_bit_tick,
   output logic [DATA_BIT-1:0] o_data,
   output logic                o_done_tick,
   output logic                o_busy
);

   localparam int CNT_W = $clog2((TICK_10K_HZ > TICK_20K_HZ) ? TICK_10K_HZ : TICK_20K_HZ);
   localparam int BIT_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

   // Per-speed counter landmarks: last count, the count before it, and mid-bit
   localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(TICK_10K_HZ - 1);
   localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(TICK_20K_HZ - 1);
   localparam logic [CNT_W-1:0] LO_PRE  = CNT_W'(TICK_10K_HZ - 2);
   localparam logic [CNT_W-1:0] HI_PRE  = CNT_W'(TICK_20K_HZ - 2);
   localparam logic [CNT_W-1:0] LO_MID  = CNT_W'(TICK_10K_HZ / 2);
   localparam logic [CNT_W-1:0] HI_MID  = CNT_W'(TICK_20K_HZ / 2);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BIT - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

`ifdef MAJORITY_VOTE_EN
   // Two-of-three majority of the samples taken around mid-bit
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
`endif

   state_t                state_q,     state_d;
   logic                  sync1_q,     sync1_d;
   logic                  sync2_q,     sync2_d;
   logic                  sel_q,       sel_d;
   logic                  mode_q,      mode_d;
   logic [CNT_W-1:0]      cnt_q,       cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
   logic [DATA_BIT-1:0]   shift_q,     shift_d;
   logic [DATA_BIT-1:0]   data_q,      data_d;
   logic                  bit_tick_q,  bit_tick_d;
   logic                  done_tick_q, done_tick_d;
   logic                  busy_q,      busy_d;
`ifdef MAJORITY_VOTE_EN
   logic                  samp_a_q,    samp_a_d;
   logic                  samp_b_q,    samp_b_d;
`endif

   logic [CNT_W-1:0]      last_s;
   logic [CNT_W-1:0]      pre_s;
   logic [CNT_W-1:0]      mid_s;

   // Counter landmarks for the bit currently being received
   always_comb begin
      if (sel_q) begin
         last_s = HI_LAST;
         pre_s  = HI_PRE;
         mid_s  = HI_MID;
      end else begin
         last_s = LO_LAST;
         pre_s  = LO_PRE;
         mid_s  = LO_MID;
      end
   end

   // Next-state logic: synchroniser, bit timing, sampling and frame completion
   always_comb begin
      state_d     = state_q;
      sync1_d     = i_serial;
      sync2_d     = sync1_q;
      sel_d       = sel_q;
      mode_d      = mode_q;
      cnt_d       = cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      data_d      = data_q;
      bit_tick_d  = 1'b0;
      done_tick_d = 1'b0;
`ifdef MAJORITY_VOTE_EN
      samp_a_d    = samp_a_q;
      samp_b_d    = samp_b_q;
`endif
      case (state_q)
         IDLE: begin
            sel_d     = i_sel_freq;
            mode_d    = i_mode;
            cnt_d     = '0;
            bit_cnt_d = '0;
            if (i_start && !i_stop) begin
               state_d = RECV;
            end else begin
               state_d = IDLE;
            end
         end
         RECV: begin
            if (i_stop) begin
               // Abort: the partial frame is dropped and o_data is left alone
               state_d   = IDLE;
               cnt_d     = '0;
               bit_cnt_d = '0;
            end else begin
`ifdef MAJORITY_VOTE_EN
               if (cnt_q == (mid_s - CNT_W'(1))) begin
                  samp_a_d = sync2_q;
               end else begin
                  samp_a_d = samp_a_q;
               end
               if (cnt_q == mid_s) begin
                  samp_b_d = sync2_q;
               end else begin
                  samp_b_d = samp_b_q;
               end
               if (cnt_q == (mid_s + CNT_W'(1))) begin
                  shift_d[bit_cnt_q] = maj3(samp_a_q, samp_b_q, sync2_q);
               end else begin
                  shift_d = shift_q;
               end
`else
               if (cnt_q == mid_s) begin
                  shift_d[bit_cnt_q] = sync2_q;
               end else begin
                  shift_d = shift_q;
               end
`endif
               // Ticks are set one count early so the registered pulses
               // line up with count P-1
               if (cnt_q == pre_s) begin
                  bit_tick_d = 1'b1;
                  if (bit_cnt_q == LAST_BIT) begin
                     done_tick_d = 1'b1;
                     data_d      = shift_q;
                  end else begin
                     done_tick_d = 1'b0;
                  end
               end else begin
                  bit_tick_d = 1'b0;
               end
               if (cnt_q == last_s) begin
                  cnt_d = '0;
                  sel_d = i_sel_freq;
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_d = '0;
                     if (mode_q) begin
                        state_d = RECV;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d   = IDLE;
            cnt_d     = '0;
            bit_cnt_d = '0;
         end
      endcase
      busy_d = (state_d == RECV);
   end

   // State and output registers with asynchronous active-high reset
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q     <= IDLE;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sel_q       <= 1'b0;
         mode_q      <= 1'b0;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         bit_tick_q  <= 1'b0;
         done_tick_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef MAJORITY_VOTE_EN
         samp_a_q    <= 1'b0;
         samp_b_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         sel_q       <= sel_d;
         mode_q      <= mode_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         bit_tick_q  <= bit_tick_d;
         done_tick_q <= done_tick_d;
         busy_q      <= busy_d;
`ifdef MAJORITY_VOTE_EN
         samp_a_q    <= samp_a_d;
         samp_b_q    <= samp_b_d;
`endif
      end
   end

   assign o_bit_tick  = bit_tick_q;
   assign o_done_tick = done_tick_q;
   assign o_data      = data_q;
   assign o_busy      = busy_q;

endmodule
